// File: rtl/seq_divider_if.sv
// Start/done request bus between the execute stage (master) and seq_divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_by_zero;

    modport master (
        output i_start, i_signed, i_dividend, i_divisor,
        input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );

    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor,
        output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock (DIV/DIVU/REM/REMU).
// Optional macro SEQ_DIV_FAST_ZERO_EN: zero divisor bypasses the iteration phase.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dq_reg;        // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] div_mag_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] div_inv;
    logic [WIDTH+1:0] trial_next;

    always_comb begin
        a_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
        b_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
        a_mag = a_neg ? (~bus.i_dividend + WIDTH'(1)) : bus.i_dividend;
        b_mag = b_neg ? (~bus.i_divisor + WIDTH'(1)) : bus.i_divisor;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
            assign div_inv[gi] = ~div_mag_reg[gi];
        end
    endgenerate

    // The shifted remainder can reach 2*divisor-1, so the subtract carries two
    // extra bits; the top bit is the borrow that decides restore vs. keep.
    assign trial_next = {1'b0, rem_reg, dq_reg[WIDTH-1]} + {2'b11, div_inv} + (WIDTH+2)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            dq_reg        <= '0;
            div_mag_reg   <= '0;
            dividend_reg  <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    // busy_reg still set here means we are in the done cycle
                    if (bus.i_start && !busy_reg) begin
                        busy_reg     <= 1'b1;
                        rem_reg      <= '0;
                        dq_reg       <= a_mag;
                        div_mag_reg  <= b_mag;
                        dividend_reg <= bus.i_dividend;
                        q_neg_reg    <= a_neg ^ b_neg;
                        r_neg_reg    <= a_neg;
                        zero_reg     <= (bus.i_divisor == '0);
                        count_reg    <= CW'(WIDTH);
`ifdef SEQ_DIV_FAST_ZERO_EN
                        state_reg    <= (bus.i_divisor == '0) ? FIX : RUN;
`else
                        state_reg    <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (trial_next[WIDTH+1]) begin
                        rem_reg <= {rem_reg[WIDTH-2:0], dq_reg[WIDTH-1]};
                        dq_reg  <= {dq_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_reg <= trial_next[WIDTH-1:0];
                        dq_reg  <= {dq_reg[WIDTH-2:0], 1'b1};
                    end
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                    if (zero_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_reg;
                        dbz_reg       <= 1'b1;
                    end else begin
                        quotient_reg  <= q_neg_reg ? (~dq_reg + WIDTH'(1)) : dq_reg;
                        remainder_reg <= r_neg_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy        = busy_reg;
    assign bus.o_done        = done_reg;
    assign bus.o_quotient    = quotient_reg;
    assign bus.o_remainder   = remainder_reg;
    assign bus.o_div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector self-checking bench for seq_divider at WIDTH=8.
module tb_seq_divider;
    localparam int W   = 8;
    localparam int LAT = W + 1;
`ifdef SEQ_DIV_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(dif.o_busy), 32'd0);
        check({tag, "_done"}, 32'(dif.o_done), 32'd0);
        check({tag, "_quot"}, 32'(dif.o_quotient), 32'd0);
        check({tag, "_rem"},  32'(dif.o_remainder), 32'd0);
        check({tag, "_dbz"},  32'(dif.o_div_by_zero), 32'd0);
    endtask

    // Runs one division; glitch > 0 pulses i_start with 100/3 on that edge count.
    task automatic run_div(input string tag, input bit sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] q,
                           input logic [W-1:0] r, input bit dz, input int lat,
                           input int glitch);
        int n;
        int dones;
        bit seen;
        n = 0;
        dones = 0;
        seen = 1'b0;
        dif.i_signed   = sgn;
        dif.i_dividend = a;
        dif.i_divisor  = b;
        dif.i_start    = 1'b1;
        @(posedge clk); #1;
        dif.i_start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(dif.o_busy), 32'd1);
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (dif.o_done) begin
                seen = 1'b1;
                dones++;
            end else if (n == glitch) begin
                dif.i_start    = 1'b1;
                dif.i_dividend = 8'd100;
                dif.i_divisor  = 8'd3;
            end else begin
                dif.i_start = 1'b0;
            end
        end
        dif.i_start = 1'b0;
        $display("div %s: %0h/%0h signed=%0d -> q=%0h r=%0h dbz=%0d after %0d edges",
                 tag, a, b, sgn, dif.o_quotient, dif.o_remainder, dif.o_div_by_zero, n);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_quot"}, 32'(dif.o_quotient), 32'(q));
        check({tag, "_rem"},  32'(dif.o_remainder), 32'(r));
        check({tag, "_dbz"},  32'(dif.o_div_by_zero), 32'(dz));
        check({tag, "_busy_in_done"}, 32'(dif.o_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (dif.o_done) dones++;
        end
        check({tag, "_done_count"}, 32'(dones), 32'd1);
        check({tag, "_busy_after"}, 32'(dif.o_busy), 32'd0);
        check({tag, "_quot_held"}, 32'(dif.o_quotient), 32'(q));
    endtask

    initial begin
        int late_dones;
        dif.i_start    = 1'b0;
        dif.i_signed   = 1'b0;
        dif.i_dividend = '0;
        dif.i_divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("u200_7",    1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, LAT, 0);
        run_div("s-7_2",     1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0, LAT, 0);
        run_div("s7_-2",     1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0, LAT, 0);
        run_div("s-128_-1",  1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0, LAT, 0);
        run_div("s-100_7",   1'b1, 8'h9C,  8'h07, 8'hF2,  8'hFE, 1'b0, LAT, 0);
        run_div("u255_16",   1'b0, 8'hFF,  8'h10, 8'h0F,  8'h0F, 1'b0, LAT, 0);
        run_div("u_dbz",     1'b0, 8'h55,  8'h00, 8'hFF,  8'h55, 1'b1, ZLAT, 0);
        run_div("s_dbz",     1'b1, 8'h55,  8'h00, 8'hFF,  8'h55, 1'b1, ZLAT, 0);
        run_div("ignore",    1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, LAT, 3);

        // Abort an operation part-way through RUN; outputs must clear with no done.
        run_div("s_dbz2",    1'b1, 8'h55,  8'h00, 8'hFF,  8'h55, 1'b1, ZLAT, 0);
        dif.i_signed   = 1'b0;
        dif.i_dividend = 8'd200;
        dif.i_divisor  = 8'd7;
        dif.i_start    = 1'b1;
        @(posedge clk); #1;
        dif.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("abort: reset applied 4 edges into RUN");
        check_zero_outputs("abort");
        late_dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dif.o_done) late_dones++;
        end
        check("abort_no_done", 32'(late_dones), 32'd0);

        run_div("u9_4",      1'b0, 8'd9,   8'd4,  8'd2,   8'd1,  1'b0, LAT, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
